decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage.sv | 113 +++++++++++
 tb/tb_decode_stage.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// decode_stage: registers a decoded control bundle per accepted command, with a
// load-use interlock that inserts one bubble and issue/bubble counters.
module decode_stage #(
    parameter int HAZARD_EN = 1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_cmd,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       s_alu,
    output logic [2:0]       wr_addr,
    output logic [2:0]       cond,
    output logic [2:0]       op2,
    output logic             reg_we,
    output logic             mem_we,
    output logic             pc_load,
    output logic             sign_ex,
    output logic             in_mux,
    output logic             adr_mux,
    output logic             ar_mux,
    output logic             br_mux,
    output logic [CNT_W-1:0] issue_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);
    logic [1:0] cls;
    logic [3:0] fn;
    logic [4:0] top;
    logic [3:0] d_alu;
    logic [2:0] d_wr;
    logic       d_we, d_mwe, d_pc, d_sx, d_in, d_adr, d_ar, d_br;
    logic       stall, accept, xfer, bubble;

    assign cls = in_cmd[15:14];
    assign fn  = in_cmd[7:4];
    assign top = in_cmd[15:11];

    always_comb begin
        d_alu = (cls == 2'b11) ? ((fn == 4'b0101) ? 4'b0001 : (fn == 4'b0110) ? 4'b1100 : fn) :
                !cls[1] ? 4'b0000 :
                (top == 5'b10000) ? 4'b1100 :
                (top == 5'b10001 || top == 5'b10100 || top == 5'b10111) ? 4'b0000 : 4'b1111;
        d_wr  = (cls == 2'b00) ? in_cmd[13:11] : in_cmd[10:8];
        d_we  = (cls == 2'b11 && fn <= 4'b1100 && fn != 4'b0101) || cls == 2'b00 || in_cmd[15:12] == 4'b1000;
        d_mwe = cls == 2'b01;
        d_pc  = top == 5'b10100 || top == 5'b10111;
        d_sx  = cls != 2'b11;
        d_in  = cls == 2'b11 && fn == 4'b1100;
        d_adr = (cls == 2'b11 && fn <= 4'b1011) || cls == 2'b10;
        d_ar  = cls == 2'b11 && fn <= 4'b0110;
        d_br  = !(cls == 2'b10 && in_cmd[13]);
    end

    assign in_ready = (!out_valid || out_ready) && !stall && !flush;
    assign accept   = in_valid && in_ready;
    assign xfer     = out_valid && out_ready && !flush;
    assign bubble   = stall && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            s_alu      <= 4'b1111;
            wr_addr    <= '0;
            cond       <= '0;
            op2        <= '0;
            {reg_we, mem_we, pc_load, sign_ex, in_mux, adr_mux, ar_mux} <= '0;
            br_mux     <= 1'b1;
            issue_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            out_valid <= accept || (out_valid && !out_ready && !flush);
            if (accept) begin
                s_alu   <= d_alu;
                wr_addr <= d_wr;
                cond    <= in_cmd[10:8];
                op2     <= in_cmd[13:11];
                {reg_we, mem_we, pc_load, sign_ex, in_mux, adr_mux, ar_mux, br_mux} <=
                    {d_we, d_mwe, d_pc, d_sx, d_in, d_adr, d_ar, d_br};
            end
            issue_cnt  <= issue_cnt + CNT_W'(xfer);
            bubble_cnt <= bubble_cnt + CNT_W'(bubble);
        end
    end

    if (HAZARD_EN != 0) begin : g_haz
        logic       ld_pend;
        logic [2:0] ld_rd;
        logic       held_ld;
        // Only a cls=00 bundle has sign_ex=1 with mem_we=0 and adr_mux=0.
        assign held_ld = sign_ex && !mem_we && !adr_mux;
        assign stall   = in_valid && ld_pend &&
                         (in_cmd[10:8] == ld_rd || (cls[0] && in_cmd[13:11] == ld_rd));
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                ld_pend <= 1'b0;
                ld_rd   <= '0;
            end else if (flush) begin
                ld_pend <= 1'b0;
            end else if (xfer) begin
                ld_pend <= held_ld;
                ld_rd   <= wr_addr;
            end else if (stall) begin
                ld_pend <= 1'b0;
            end
        end
    end else begin : g_nohaz
        assign stall = 1'b0;
    end
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed scenarios plus a randomized run against a
// cycle-level reference model of the decode stage.
module tb_decode_stage;
    logic        clk = 0, rst_n = 0;
    logic        in_valid = 0, flush = 0, out_ready = 0;
    logic [15:0] in_cmd = 0;
    logic        in_ready, out_valid;
    logic [3:0]  s_alu;
    logic [2:0]  wr_addr, cond, op2;
    logic        reg_we, mem_we, pc_load, sign_ex, in_mux, adr_mux, ar_mux, br_mux;
    logic [15:0] issue_cnt, bubble_cnt;

    logic        v2 = 0, f2 = 0, r2 = 0;
    logic [15:0] c2 = 0;
    logic        in_ready2, out_valid2;
    logic [3:0]  s_alu2;
    logic [2:0]  wr_addr2, cond2, op22;
    logic        reg_we2, mem_we2, pc_load2, sign_ex2, in_mux2, adr_mux2, ar_mux2, br_mux2;
    logic [1:0]  issue_cnt2, bubble_cnt2;

    int pass = 0, total = 0, e_iss = 0, e_bub = 0;

    wire [20:0] got  = {s_alu, wr_addr, cond, op2, reg_we, mem_we, pc_load, sign_ex, in_mux, adr_mux, ar_mux, br_mux};
    wire [20:0] got2 = {s_alu2, wr_addr2, cond2, op22, reg_we2, mem_we2, pc_load2, sign_ex2, in_mux2, adr_mux2, ar_mux2, br_mux2};
    localparam logic [20:0] RST_B = 21'h1E0001;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_cmd(in_cmd),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .s_alu(s_alu),
        .wr_addr(wr_addr), .cond(cond), .op2(op2), .reg_we(reg_we), .mem_we(mem_we),
        .pc_load(pc_load), .sign_ex(sign_ex), .in_mux(in_mux), .adr_mux(adr_mux),
        .ar_mux(ar_mux), .br_mux(br_mux), .issue_cnt(issue_cnt), .bubble_cnt(bubble_cnt)
    );

    decode_stage #(.HAZARD_EN(0), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_ready(in_ready2), .in_cmd(c2),
        .flush(f2), .out_valid(out_valid2), .out_ready(r2), .s_alu(s_alu2),
        .wr_addr(wr_addr2), .cond(cond2), .op2(op22), .reg_we(reg_we2), .mem_we(mem_we2),
        .pc_load(pc_load2), .sign_ex(sign_ex2), .in_mux(in_mux2), .adr_mux(adr_mux2),
        .ar_mux(ar_mux2), .br_mux(br_mux2), .issue_cnt(issue_cnt2), .bubble_cnt(bubble_cnt2)
    );

    function automatic logic [20:0] ref_bundle(input logic [15:0] c);
        int k = int'(c[15:14]);
        int f = int'(c[7:4]);
        int t = int'(c[15:11]);
        logic [3:0] alu;
        logic we;
        if (k == 3) alu = (f == 5) ? 4'd1 : (f == 6) ? 4'd12 : 4'(f);
        else if (k < 2) alu = 4'd0;
        else if (t == 16) alu = 4'd12;
        else if (t == 17 || t == 20 || t == 23) alu = 4'd0;
        else alu = 4'd15;
        we = (k == 3 && f <= 12 && f != 5) || k == 0 || c[15:12] == 4'd8;
        return {alu, (k == 0) ? c[13:11] : c[10:8], c[10:8], c[13:11], we, k == 1, t == 20 || t == 23,
                k != 3, k == 3 && f == 12, (k == 3 && f <= 11) || k == 2, k == 3 && f <= 6, !(k == 2 && c[13])};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #23;
        total++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", out_valid); else pass++;
        total++; if (got !== RST_B) $display("FAIL reset_bundle got %h exp %h", got, RST_B); else pass++;
        total++; if ({issue_cnt, bubble_cnt} !== 32'd0) $display("FAIL reset_cnt got %h exp 0", {issue_cnt, bubble_cnt}); else pass++;
        @(negedge clk);
        rst_n = 1; in_valid = 1; in_cmd = 16'hC350; out_ready = 1;
    endtask

    task automatic test_alu();
        tick();
        in_valid = 0;
        total++; if (out_valid !== 1'b1) $display("FAIL alu_valid got %b exp 1", out_valid); else pass++;
        total++; if ({s_alu, reg_we, ar_mux, adr_mux, sign_ex} !== 8'b0001_0110)
            $display("FAIL alu_fields got %b exp 00010110", {s_alu, reg_we, ar_mux, adr_mux, sign_ex}); else pass++;
        total++; if (got !== ref_bundle(16'hC350)) $display("FAIL alu_bundle got %h exp %h", got, ref_bundle(16'hC350)); else pass++;
        tick(); e_iss++;
        total++; if (out_valid !== 1'b0 || issue_cnt !== 16'(e_iss))
            $display("FAIL alu_after got v=%b cnt=%0d exp v=0 cnt=%0d", out_valid, issue_cnt, e_iss); else pass++;
    endtask

    task automatic test_backpressure();
        in_valid = 1; in_cmd = 16'h8800; out_ready = 0;
        tick();
        in_cmd = 16'hC350;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (!out_valid || s_alu !== 4'd0 || !reg_we || in_ready !== 1'b0 || got !== ref_bundle(16'h8800))
                $display("FAIL bp_hold%0d got v=%b b=%h rdy=%b exp v=1 b=%h rdy=0", i, out_valid, got, in_ready, ref_bundle(16'h8800)); else pass++;
            tick();
        end
        in_valid = 0; out_ready = 1;
        tick(); e_iss++;
        total++; if (out_valid !== 1'b0 || issue_cnt !== 16'(e_iss))
            $display("FAIL bp_release got v=%b cnt=%0d exp v=0 cnt=%0d", out_valid, issue_cnt, e_iss); else pass++;
    endtask

    task automatic test_load_use();
        in_valid = 1; in_cmd = 16'h1000; out_ready = 1;
        tick();
        in_valid = 0;
        tick(); e_iss++;
        in_valid = 1; in_cmd = 16'hC210;
        #1;
        total++; if (in_ready !== 1'b0 || out_valid !== 1'b0)
            $display("FAIL lu_bubble got rdy=%b v=%b exp rdy=0 v=0", in_ready, out_valid); else pass++;
        tick(); e_bub++;
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || bubble_cnt !== 16'(e_bub))
            $display("FAIL lu_after got rdy=%b v=%b bub=%0d exp rdy=1 v=0 bub=%0d", in_ready, out_valid, bubble_cnt, e_bub); else pass++;
        tick();
        in_valid = 0;
        total++; if (out_valid !== 1'b1 || got !== ref_bundle(16'hC210))
            $display("FAIL lu_issue got v=%b b=%h exp v=1 b=%h", out_valid, got, ref_bundle(16'hC210)); else pass++;
        tick(); e_iss++;
    endtask

    task automatic test_flush();
        in_valid = 1; in_cmd = 16'h1000; out_ready = 0;
        tick();
        in_valid = 0; flush = 1;
        #1;
        total++; if (in_ready !== 1'b0 || out_valid !== 1'b1)
            $display("FAIL fl_block got rdy=%b v=%b exp rdy=0 v=1", in_ready, out_valid); else pass++;
        tick();
        flush = 0;
        #1;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || issue_cnt !== 16'(e_iss) || bubble_cnt !== 16'(e_bub))
            $display("FAIL fl_clear got v=%b rdy=%b iss=%0d bub=%0d exp v=0 rdy=1 iss=%0d bub=%0d",
                     out_valid, in_ready, issue_cnt, bubble_cnt, e_iss, e_bub); else pass++;
        in_valid = 1; in_cmd = 16'h1000; out_ready = 1;
        tick();
        in_valid = 0;
        tick(); e_iss++;
        in_valid = 1; in_cmd = 16'hC210; flush = 1;
        #1;
        total++; if (in_ready !== 1'b0) $display("FAIL fl_prio got rdy=%b exp 0", in_ready); else pass++;
        tick();
        flush = 0;
        #1;
        total++; if (in_ready !== 1'b1 || bubble_cnt !== 16'(e_bub))
            $display("FAIL fl_ldpend got rdy=%b bub=%0d exp rdy=1 bub=%0d", in_ready, bubble_cnt, e_bub); else pass++;
        tick();
        in_valid = 0;
        tick(); e_iss++;
    endtask

    task automatic test_random();
        logic        m_ov = 0, m_ld = 0, m_ldp = 0, haz, xf, acc, er;
        logic [2:0]  m_rd = 0, m_ldrd = 0;
        logic [20:0] m_b = 0;
        int          errs = 0;
        for (int n = 0; n < 400; n++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_cmd = 16'($urandom);
            if ($urandom_range(0, 1) == 1) in_cmd[15:14] = 2'b00;
            out_ready = $urandom_range(0, 3) != 0;
            flush = $urandom_range(0, 15) == 0;
            #1;
            haz = in_valid && m_ldp && (in_cmd[10:8] == m_ldrd || ((in_cmd[15:14] == 2'd1 || in_cmd[15:14] == 2'd3) && in_cmd[13:11] == m_ldrd));
            er = (!m_ov || out_ready) && !haz && !flush;
            total++;
            if (in_ready !== er || out_valid !== m_ov || (m_ov && got !== m_b) || issue_cnt !== 16'(e_iss) || bubble_cnt !== 16'(e_bub)) begin
                errs++;
                if (errs < 10) $display("FAIL rand%0d got rdy=%b v=%b b=%h iss=%0d bub=%0d exp rdy=%b v=%b b=%h iss=%0d bub=%0d",
                                        n, in_ready, out_valid, got, issue_cnt, bubble_cnt, er, m_ov, m_b, e_iss, e_bub);
            end else pass++;
            xf = m_ov && out_ready && !flush;
            acc = in_valid && er;
            if (xf) e_iss++;
            if (haz && !flush) e_bub++;
            m_ldp = flush ? 1'b0 : xf ? m_ld : haz ? 1'b0 : m_ldp;
            if (xf) m_ldrd = m_rd;
            m_ov = acc || (m_ov && !out_ready && !flush);
            if (acc) begin
                m_b = ref_bundle(in_cmd);
                m_ld = in_cmd[15:14] == 2'b00;
                m_rd = m_b[16:14];
            end
            tick();
        end
        in_valid = 0; flush = 0; out_ready = 1;
    endtask

    task automatic test_nohaz_wrap_reset();
        v2 = 1; c2 = 16'h1000; r2 = 1;
        tick();
        v2 = 0;
        tick();
        v2 = 1; c2 = 16'hC210;
        #1;
        total++; if (in_ready2 !== 1'b1) $display("FAIL nh_ready got %b exp 1", in_ready2); else pass++;
        tick();
        c2 = 16'hC350;
        repeat (3) tick();
        v2 = 0;
        tick();
        total++; if (issue_cnt2 !== 2'b01 || bubble_cnt2 !== 2'b00 || out_valid2 !== 1'b0)
            $display("FAIL nh_wrap got iss=%b bub=%b v=%b exp iss=01 bub=00 v=0", issue_cnt2, bubble_cnt2, out_valid2); else pass++;
        v2 = 1; r2 = 0;
        tick();
        v2 = 0;
        total++; if (out_valid2 !== 1'b1) $display("FAIL nh_held got %b exp 1", out_valid2); else pass++;
        #2 rst_n = 0;
        #1;
        total++; if (out_valid2 !== 1'b0 || got2 !== RST_B || {issue_cnt2, bubble_cnt2} !== 4'd0 || issue_cnt !== 16'd0)
            $display("FAIL rst_async got v=%b b=%h cnt=%b main=%0d exp v=0 b=%h cnt=0 main=0",
                     out_valid2, got2, {issue_cnt2, bubble_cnt2}, issue_cnt, RST_B); else pass++;
        @(negedge clk);
        rst_n = 1; v2 = 1; c2 = 16'hC350; r2 = 1;
        tick();
        v2 = 0;
        total++; if (out_valid2 !== 1'b1 || s_alu2 !== 4'b0001)
            $display("FAIL rst_first got v=%b alu=%b exp v=1 alu=0001", out_valid2, s_alu2); else pass++;
    endtask

    initial begin
        test_reset();
        test_alu();
        test_backpressure();
        test_load_use();
        test_flush();
        test_random();
        test_nohaz_wrap_reset();
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
